// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO for the datapath output stage.
// Optional sticky overflow flag enabled by defining RESULT_FIFO_OVF_EN.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din_low,
  input  logic [WIDTH-1:0]           din_high,
  input  logic                       zero_in,
  input  logic                       error_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout_low,
  output logic [WIDTH-1:0]           dout_high,
  output logic                       zero_out,
  output logic                       error_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          push, pop;
  logic [EW-1:0] head;

  // A full FIFO still accepts a write when the same edge pops the head.
  assign push = wr_en && (!full_q || rd_en);
  assign pop  = rd_en && !empty_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {din_high, din_low, zero_in, error_in};
  end

  always_comb begin
    head = '0;
    if (!empty_q) head = mem_q[rd_ptr_q];
  end

  assign {dout_high, dout_low, zero_out, error_out} = head;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

`ifdef RESULT_FIFO_OVF_EN
  logic overflow_q, overflow_d;
  logic drop;

  assign drop = wr_en && full_q && !rd_en;

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = ovf_clr;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo: vector table plus reset/overflow sequences.
module tb_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef RESULT_FIFO_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [WIDTH-1:0] din_low = '0, din_high = '0;
  logic             zero_in = 1'b0, error_in = 1'b0;
  logic [WIDTH-1:0] dout_low, dout_high;
  logic             zero_out, error_out, empty, full, overflow;
  logic [2:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din_low(din_low), .din_high(din_high),
    .zero_in(zero_in), .error_in(error_in), .rd_en(rd_en),
    .dout_low(dout_low), .dout_high(dout_high), .zero_out(zero_out),
    .error_out(error_out), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       wr, rd, clr;
    bit [7:0] hi, lo;
    bit       z, e;
    bit [7:0] ehi, elo;
    bit       ez, ee, eempty, efull;
    int       ecount;
    bit       eovf;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(bit wr, bit rd, bit clr, bit [7:0] hi, bit [7:0] lo,
                             bit z, bit e, bit [7:0] ehi, bit [7:0] elo, bit ez,
                             bit ee, bit eempty, bit efull, int ecount, bit eovf);
    vec_t r;
    r.wr = wr; r.rd = rd; r.clr = clr; r.hi = hi; r.lo = lo; r.z = z; r.e = e;
    r.ehi = ehi; r.elo = elo; r.ez = ez; r.ee = ee; r.eempty = eempty;
    r.efull = efull; r.ecount = ecount; r.eovf = eovf;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit [7:0] ehi, input bit [7:0] elo,
                           input bit ez, input bit ee, input bit eempty,
                           input bit efull, input int ecount, input bit eovf);
    check({tag, ".dout_high"}, int'(dout_high), int'(ehi));
    check({tag, ".dout_low"},  int'(dout_low),  int'(elo));
    check({tag, ".zero_out"},  int'(zero_out),  int'(ez));
    check({tag, ".error_out"}, int'(error_out), int'(ee));
    check({tag, ".empty"},     int'(empty),     int'(eempty));
    check({tag, ".full"},      int'(full),      int'(efull));
    check({tag, ".count"},     int'(count),     ecount);
    check({tag, ".overflow"},  int'(overflow),  int'(eovf));
  endtask

  task automatic drive(input bit wr, input bit rd, input bit clr, input bit [7:0] hi,
                       input bit [7:0] lo, input bit z, input bit e);
    wr_en = wr; rd_en = rd; ovf_clr = clr;
    din_high = hi; din_low = lo; zero_in = z; error_in = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            wr rd clr hi     lo     z  e  ehi    elo    ez ee emp ful cnt ovf
    tbl[0]  = v(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 8'h12, 8'h34, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0, 1, 0);
    tbl[2]  = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    tbl[3]  = v(1, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0, 1, 0);
    tbl[4]  = v(1, 0, 0, 8'h00, 8'h02, 0, 1, 8'h00, 8'h01, 0, 0, 0, 0, 2, 0);
    tbl[5]  = v(1, 0, 0, 8'h00, 8'h03, 1, 0, 8'h00, 8'h01, 0, 0, 0, 0, 3, 0);
    tbl[6]  = v(1, 0, 0, 8'h00, 8'h04, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 4, 0);
    tbl[7]  = v(1, 0, 0, 8'hFF, 8'h05, 1, 1, 8'h00, 8'h01, 0, 0, 0, 1, 4, OVF);
    tbl[8]  = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 0, 1, 0, 0, 3, OVF);
    tbl[9]  = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h03, 1, 0, 0, 0, 2, OVF);
    tbl[10] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h04, 0, 0, 0, 0, 1, OVF);
    tbl[11] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, OVF);
    tbl[12] = v(0, 0, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    tbl[13] = v(1, 0, 0, 8'hA1, 8'h11, 0, 0, 8'hA1, 8'h11, 0, 0, 0, 0, 1, 0);
    tbl[14] = v(1, 0, 0, 8'hA2, 8'h22, 0, 0, 8'hA1, 8'h11, 0, 0, 0, 0, 2, 0);
    tbl[15] = v(1, 0, 0, 8'hA3, 8'h33, 0, 0, 8'hA1, 8'h11, 0, 0, 0, 0, 3, 0);
    tbl[16] = v(1, 0, 0, 8'hA4, 8'h44, 0, 0, 8'hA1, 8'h11, 0, 0, 0, 1, 4, 0);
    tbl[17] = v(1, 1, 0, 8'hBB, 8'hAA, 1, 0, 8'hA2, 8'h22, 0, 0, 0, 1, 4, 0);
    tbl[18] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'hA3, 8'h33, 0, 0, 0, 0, 3, 0);
    tbl[19] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'hA4, 8'h44, 0, 0, 0, 0, 2, 0);
    tbl[20] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'hBB, 8'hAA, 1, 0, 0, 0, 1, 0);
    tbl[21] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    tbl[22] = v(1, 1, 0, 8'hC3, 8'h5A, 0, 1, 8'hC3, 8'h5A, 0, 1, 0, 0, 1, 0);
    tbl[23] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    tbl[24] = v(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);

    // Reset held for a few edges: outputs already quiescent.
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset", 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].hi, tbl[i].lo, tbl[i].z, tbl[i].e);
      check_all($sformatf("vec%0d", i), tbl[i].ehi, tbl[i].elo, tbl[i].ez, tbl[i].ee,
                tbl[i].eempty, tbl[i].efull, tbl[i].ecount, tbl[i].eovf);
    end

    // Fill, drop a push, pop one, then assert reset mid-cycle with 3 entries held.
    for (int i = 1; i <= 4; i++) drive(1, 0, 0, 8'h00, 8'(8'h60 + i), 0, 0);
    drive(1, 0, 0, 8'h00, 8'h6F, 0, 0);
    check_all("pre_drop", 8'h00, 8'h61, 0, 0, 0, 1, 4, OVF);
    drive(0, 1, 0, 8'h00, 8'h00, 0, 0);
    check_all("three_held", 8'h00, 8'h62, 0, 0, 0, 0, 3, OVF);
    wr_en = 1'b0; rd_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all("post_rst", 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);

    // First edge after release must accept a push.
    drive(1, 0, 0, 8'h88, 8'h77, 0, 0);
    check_all("first_push", 8'h88, 8'h77, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'h00, 8'(8'h78 + i), 0, 0);
    check_all("refill", 8'h88, 8'h77, 0, 0, 0, 1, 4, 0);

    // Dropped push and ovf_clr on the same edge: set wins.
    drive(1, 0, 1, 8'h00, 8'hEE, 0, 0);
    check_all("set_wins", 8'h88, 8'h77, 0, 0, 0, 1, 4, OVF);
    drive(0, 0, 1, 8'h00, 8'h00, 0, 0);
    check_all("clr", 8'h88, 8'h77, 0, 0, 0, 1, 4, 0);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the width of each result half (low and high).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The module SHALL have the following ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Reset; asynchronous, active-low.
- wr_en  input  1  Push strobe from the datapath output-register enable.
- din_low  input  WIDTH  Low half of the datapath result.
- din_high  input  WIDTH  High half of the datapath result.
- zero_in  input  1  Datapath zero flag.
- error_in  input  1  Datapath error flag.
- rd_en  input  1  Pop strobe from the consumer.
- dout_low  output  WIDTH  Low half of the head entry.
- dout_high  output  WIDTH  High half of the head entry.
- zero_out  output  1  Zero flag of the head entry.
- error_out  output  1  Error flag of the head entry.
- empty  output  1  High when no entries are stored.
- full  output  1  High when DEPTH entries are stored.
- count  output  clog2(DEPTH)+1  Number of stored entries.
- overflow  output  1  Sticky flag: a push was dropped.
- ovf_clr  input  1  Synchronous clear of overflow.

Function
REQ-004 Each entry SHALL be a packed record {din_high, din_low, zero_in, error_in} of 2*WIDTH+2 bits, stored in a circular buffer with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-005 The outputs SHALL be first-word-fall-through: while empty=0, dout_high, dout_low, zero_out and error_out SHALL present the head entry combinationally from storage, with no read latency.
REQ-006 While empty=1, dout_high, dout_low, zero_out and error_out SHALL be 0.
REQ-007 A push (wr_en=1, full=0) SHALL store the entry and make it visible at the outputs in the cycle after the edge; a write into an empty FIFO therefore has 1-cycle latency to dout.
REQ-008 A pop (rd_en=1, empty=0) SHALL advance the read pointer, so the next entry, or zeros, appears after the edge.
REQ-009 wr_en while full=1 and rd_en=0 SHALL drop the data and leave pointers and count unchanged.
REQ-010 rd_en while empty=1 SHALL be ignored.
REQ-011 Simultaneous wr_en and rd_en with 0<count<DEPTH SHALL perform both operations, leaving count unchanged.
REQ-012 Simultaneous wr_en and rd_en when full SHALL perform both operations (pop head, push new); count SHALL stay DEPTH and nothing is dropped.
REQ-013 Simultaneous wr_en and rd_en when empty SHALL accept the write and ignore the read; count SHALL become 1.
REQ-014 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), both registered-consistent with count.

Reset
REQ-015 While rst=0, the module SHALL asynchronously force the read pointer, write pointer and count to 0, empty to 1, full to 0 and overflow to 0, and all data outputs to 0.
REQ-016 Assertion of rst mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-017 The first push SHALL be accepted on the first rising edge after rst returns to 1.

Configuration
REQ-018 When macro RESULT_FIFO_OVF_EN is defined, overflow SHALL set on any edge where a push is dropped per REQ-009, and SHALL remain set until ovf_clr=1 or reset.
REQ-019 If the set and clear conditions occur on the same edge, set SHALL win.
REQ-020 When RESULT_FIFO_OVF_EN is undefined, overflow SHALL be constant 0, ovf_clr SHALL be ignored, and no overflow register SHALL be synthesized.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset then idle -> empty=1, full=0, count=0, all data outputs 0, overflow=0.
- Push {high=0x12, low=0x34, zero=0, error=0} into an empty FIFO -> next cycle: dout_high=0x12, dout_low=0x34, count=1, empty=0.
- Push 0x01..0x04 (low), then push 0x05 -> full=1, count=4, 0x05 dropped, overflow=1 (macro defined) or 0 (undefined); pop 4 times -> outputs 0x01,0x02,0x03,0x04, then empty=1.
- With count=4 (full), assert wr_en and rd_en together with low=0xAA -> count stays 4, head advances, 0xAA is read last; overflow is not set.
- With count=0, assert wr_en and rd_en together with low=0x5A -> count=1, dout_low=0x5A.
- Push 3 entries, drop rst to 0 mid-cycle -> outputs zero immediately; after release, empty=1; assert ovf_clr with a dropped push on the same edge -> overflow=1.
